// File: rtl/mem_copy_engine.sv
// Purpose: memory-port bus master that copies (or, with MEMCPY_FILL_EN, fills) a block of bytes.
// Latency: copy N>0 -> done in cycle 2N+1 after accept; fill N>0 -> cycle N+1; N=0 -> cycle 1.
// Backpressure: none; start is only accepted in IDLE and is dropped while busy (no queueing).
// Optional fill path is compiled in only when MEMCPY_FILL_EN is defined.
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] length,
    input  logic          fill_mode,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;
    logic [LW-1:0] cnt_q;
    logic [DW-1:0] hold_q;

    // fill_start: a fill is being requested at accept; fill_run: the active transfer is a fill.
    logic          fill_start;
    logic          fill_run;
    logic [DW-1:0] wr_data;

`ifdef MEMCPY_FILL_EN
    logic          fill_q;
    logic [DW-1:0] fill_val_q;

    assign fill_start = fill_mode;
    assign fill_run   = fill_q;
    assign wr_data    = fill_q ? fill_val_q : hold_q;
`else
    // Fill inputs have no function in a copy-only build.
    logic unused_fill;

    assign unused_fill = ^{fill_mode, fill_val};
    assign fill_start  = 1'b0;
    assign fill_run    = 1'b0;
    assign wr_data     = hold_q;
`endif

    // State register; reset aborts any transfer in flight without a done pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded memory/handshake outputs.
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (fill_start) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                busy     = 1'b1;
                mem_addr = src_q;
                state_d  = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = wr_data;
                mem_we    = 1'b1;
                if (cnt_q == LW'(1)) begin
                    state_d = DONE;
                end else if (fill_run) begin
                    state_d = WRITE;
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer, count and data registers; pointers wrap naturally at 2**AW.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
`ifdef MEMCPY_FILL_EN
            fill_q     <= 1'b0;
            fill_val_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q      <= src_addr;
                        dst_q      <= dst_addr;
                        cnt_q      <= length;
`ifdef MEMCPY_FILL_EN
                        fill_q     <= fill_mode;
                        fill_val_q <= fill_val;
`endif
                    end
                end
                READ: begin
                    hold_q <= mem_rdata;
                    src_q  <= src_q + AW'(1);
                end
                WRITE: begin
                    dst_q <= dst_q + AW'(1);
                    cnt_q <= cnt_q - LW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: 256-byte memory model, reference byte array and done-time scoreboard.
// Expected completion cycle, write count and final memory image are queued at issue time.
// A negedge monitor pops one entry per done pulse and compares.
module tb_mem_copy_engine;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [7:0] length = '0;
    logic       fill_mode = 1'b0;
    logic [7:0] fill_val = '0;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    mem_copy_engine #(.AW(8), .DW(8), .LW(8)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .fill_mode (fill_mode),
        .fill_val  (fill_val),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory model: preload port for the bench, DUT writes held off while the system is in reset.
    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [7:0] pl_data = '0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge CLK) begin
        if (pl_en) mem[pl_addr] = pl_data;
        else if (mem_we && RST_N) mem[mem_addr] = mem_wdata;
    end

    typedef struct {
        int done_cyc;
        int writes;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   wcount = 0;

    function automatic void chk(string name, int act, int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Monitor: counts write strobes and scores each done pulse against the queued expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            wcount = 0;
        end else begin
            if (mem_we) wcount++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("write_count", wcount, e.writes);
                    chk("busy_at_done", busy, 1);
                    chk("mem_image", mem_diff(), 0);
                end
                wcount = 0;
            end
        end
    end

    task automatic set_mem(input logic [7:0] a, input logic [7:0] v);
        @(negedge CLK);
        pl_en = 1'b1; pl_addr = a; pl_data = v;
        @(posedge CLK); #1;
        pl_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    // Issue one transfer; reference result is applied to ref_mem by plain forward byte loop.
    task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         input logic fm, input logic [7:0] fv);
        exp_t e;
        logic fill;
        int   lat;
        wait_idle();
        @(negedge CLK);
        src_addr = s; dst_addr = d; length = l; fill_mode = fm; fill_val = fv; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
`ifdef MEMCPY_FILL_EN
        fill = fm;
`else
        fill = 1'b0;
`endif
        for (int i = 0; i < int'(l); i++) begin
            if (fill) ref_mem[8'(d + i)] = fv;
            else      ref_mem[8'(d + i)] = ref_mem[8'(s + i)];
        end
        if (l == 0)    lat = 1;
        else if (fill) lat = int'(l) + 1;
        else           lat = 2 * int'(l) + 1;
        e.done_cyc = cyc + lat - 1;
        e.writes   = int'(l);
        sb.push_back(e);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        for (int i = 0; i < 256; i++) set_mem(8'(i), 8'($urandom_range(0, 255)));

        // Basic copy, with a stray start while busy that must be ignored
        for (int i = 0; i < 4; i++) set_mem(8'(8'h10 + i), 8'(8'h0A + i));
        issue(8'h10, 8'h40, 8'd4, 1'b0, 8'h00);
        src_addr = 8'h00; dst_addr = 8'h90; length = 8'd7; start = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        start = 1'b0;
        wait_drain();
        for (int i = 0; i < 4; i++) chk($sformatf("copy_m%0h", 8'h40 + i), mem[8'(8'h40 + i)], 8'h0A + i);

        // Zero length
        issue(8'h33, 8'h44, 8'd0, 1'b0, 8'h00);
        wait_drain();

        // Address wrap
        set_mem(8'hFE, 8'd1); set_mem(8'hFF, 8'd2); set_mem(8'h00, 8'd3);
        issue(8'hFE, 8'h7F, 8'd3, 1'b0, 8'h00);
        wait_drain();
        chk("wrap_m7f", mem[8'h7F], 1);
        chk("wrap_m80", mem[8'h80], 2);
        chk("wrap_m81", mem[8'h81], 3);

        // Reset during the second write of a 4-byte copy
        set_mem(8'h50, 8'h11); set_mem(8'h51, 8'h22); set_mem(8'h52, 8'h33); set_mem(8'h53, 8'h44);
        wait_idle();
        @(negedge CLK);
        src_addr = 8'h50; dst_addr = 8'h60; length = 8'd4; fill_mode = 1'b0; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("abort_we_b2", mem_we, 1);
        chk("abort_addr_b2", mem_addr, 8'h61);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        chk("abort_busy", busy, 0);
        chk("abort_we", mem_we, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", mem_addr, 0);
        RST_N = 1'b1;
        ref_mem[8'h60] = 8'h11;
        repeat (6) @(negedge CLK);
        chk("abort_mem", mem_diff(), 0);

        // Overlapping forward copy
        set_mem(8'h20, 8'h55); set_mem(8'h21, 8'h66);
        issue(8'h20, 8'h21, 8'd2, 1'b0, 8'h00);
        wait_drain();
        chk("ovl_m21", mem[8'h21], 8'h55);
        chk("ovl_m22", mem[8'h22], 8'h55);

        // Fill request (performs a copy from src when the fill path is not built)
        issue(8'h10, 8'h30, 8'd5, 1'b1, 8'hA5);
        wait_drain();
`ifdef MEMCPY_FILL_EN
        chk("fill_m30", mem[8'h30], 8'hA5);
        chk("fill_m34", mem[8'h34], 8'hA5);
`else
        chk("nofill_m30", mem[8'h30], 8'h0A);
        chk("nofill_m33", mem[8'h33], 8'h0D);
`endif

        // Randomized transfers
        for (int t = 0; t < 30; t++) begin
            logic [7:0] l;
            if ($urandom_range(0, 3) == 0) set_mem(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            l = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), l,
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        wait_drain();
        repeat (4) @(negedge CLK);
        chk("final_mem", mem_diff(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
